vending_core: RTL and testbench
===============================

# vending_core

Parametrised vending controller: accepts coin pulses into a saturating credit register and dispenses one of `N_PROD` products by driving that product's motor for a fixed time. Returns the remaining credit on cancel, one coin at a time, and drives a `DIGITS`-digit multiplexed 7-segment display of the credit. It sits between the board-level debounced push-buttons and the motor driver and display pins, and supersedes the fixed 4-product, 2-digit controller.

## Interface
- `N_PROD`, 4: number of products, selection inputs and motors.
- `CREDIT_W`, 7: credit register width.
- `COIN_VALUE`, 5: credit added per coin and removed per refund pulse.
- `CREDIT_MAX`, 95: credit ceiling. Must be a multiple of `COIN_VALUE` and below 10^`DIGITS`.
- `PRICES`, {20,15,5,5}: packed `N_PROD`×`CREDIT_W` vector. Slice i is the price of product i.
- `MOTOR_CYCLES`, 50_000_000: motor on-time in clk cycles.
- `REFUND_CYCLES`, 25_000_000: spacing between refund pulses.
- `MUX_CYCLES`, 100_000: dwell time per display digit.
- `DIGITS`, 2: number of display digits.
- `clk` in 1: system clock, 50 MHz.
- `reset` in 1: asynchronous, active-high.
- `coin` in 1: coin button, asynchronous level.
- `sel` in `N_PROD`: product buttons, asynchronous levels.
- `cancel` in 1: refund request, asynchronous level.
- `motor` out `N_PROD`: one-hot or zero, active-high.
- `refund` out 1: one-cycle pulse per returned coin.
- `deny` out 1: one-cycle pulse on rejected coin or unaffordable selection.
- `busy` out 1: high in VEND and REFUND.
- `credit` out `CREDIT_W`: current credit.
- `seg` out 7: segments {g,f,e,d,c,b,a}, active-high.
- `an` out `DIGITS`: digit enable, one-hot, active-high. Bit 0 is the units digit.

## Operation
- All `coin`, `sel` and `cancel` bits pass through a 2-flop synchroniser, then a rising-edge detector. Only edges act. Levels never act.
- FSM states: IDLE, VEND, REFUND.
- **Coin edge (any state):**
  - If credit + `COIN_VALUE` ≤ `CREDIT_MAX`, credit increases by `COIN_VALUE`.
  - Otherwise credit is unchanged and `deny` pulses.
  - In REFUND the coin is accepted and extends the refund.
- **IDLE, sel edge(s):**
  - The lowest asserted index i wins. Other simultaneous edges are dropped.
  - If credit ≥ `PRICES[i]`: credit decreases by the price, `motor[i]`=1, the timer loads `MOTOR_CYCLES`-1, next state is VEND.
  - Otherwise `deny` pulses and the state stays IDLE.
- **IDLE, cancel edge:**
  - If credit > 0, go to REFUND and load the timer with 0.
  - Otherwise `deny` pulses.
- **Both sel and cancel edge in the same IDLE cycle:** sel wins and cancel is dropped.
- **VEND:** the timer decrements each cycle. When the timer reaches 0, `motor` clears and the state returns to IDLE. Sel and cancel edges are ignored; no `deny`.
- **REFUND:**
  - When timer = 0 and credit ≥ `COIN_VALUE`: `refund` pulses, credit decreases by `COIN_VALUE`, the timer reloads `REFUND_CYCLES`-1.
  - When timer = 0 and credit = 0: return to IDLE.
  - Otherwise the timer decrements.
  - Sel and cancel edges are ignored.
- **Display:**
  - Credit is converted to `DIGITS` BCD digits; leading zeros are shown.
  - The active digit advances every `MUX_CYCLES` cycles, cycling 0→`DIGITS`-1→0.
  - `seg` always matches the active `an` digit in the same cycle; there is no ghosting cycle.
- **Arithmetic:** all sums are computed `CREDIT_W`+1 bits wide before comparison. Credit never wraps and never goes negative.

## Timing
- **Reset values:** state IDLE, credit 0, `motor` 0, `refund` 0, `deny` 0, `busy` 0, `an` = 1, `seg` = code for '0', timers 0, synchroniser and edge registers 0.
- An input rising edge takes effect on the 3rd clk edge after it (2 synchroniser stages plus 1 edge-detect register).
- Credit, `motor`, `busy` and `deny` update on the same clk edge as the decision. All outputs are registered.
- `motor[i]` is high for exactly `MOTOR_CYCLES` cycles.
- The first `refund` pulse occurs 1 cycle after entering REFUND. Subsequent pulses are `REFUND_CYCLES` cycles apart.
- Reset mid-VEND or mid-REFUND: `motor` drops and credit clears asynchronously. No refund is issued.

## Structure
- Package `vending_pkg` holds:
  - the FSM state enum;
  - the 7-segment constants for 0–9 and blank;
  - a `bcd_digit(value, idx)` function.
- Sub-module `vending_display` contains the digit-mux counter, the BCD select and the decode. It takes `clk`, `reset` and `credit`, and outputs `seg` and `an`.
- The rest of the logic (synchroniser, FSM, timer, credit) stays in `vending_core`.

## Test plan
All scenarios use `MOTOR_CYCLES`=20, `REFUND_CYCLES`=4, `MUX_CYCLES`=3 and default prices.
- **Coin accumulation:** 4 coin presses → credit 20. Display shows `an`=01 with seg '0', then `an`=10 with seg '2'.
- **Credit saturation:** 20 coin presses → credit 95 and exactly 1 `deny` pulse.
- **Affordable vend:** credit 20, press `sel[2]` (price 15) → 3 cycles later `motor`=0100 for 20 cycles, credit 5, `busy` high for 20 cycles.
- **Unaffordable and ignored selections:**
  - Credit 10, press `sel[3]` (price 20) → `deny` pulse, credit stays 10, `motor` stays 0.
  - `sel[0]` and `sel[1]` pressed together → `motor[0]` only, credit 5.
  - `sel` pressed during VEND → ignored.
- **Refund:** credit 15, press `cancel` → 3 `refund` pulses 4 cycles apart, credit 0, return to IDLE. A coin inserted mid-refund produces a 4th pulse.
- **Reset during vend:** assert `reset` during VEND → `motor` 0 and credit 0 immediately. Next coin → credit 5.

Source files
------------

// File: rtl/vending_pkg.sv
// Shared types and helpers for the vending controller: FSM states,
// 7-segment codes and BCD digit extraction.
package vending_pkg;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_VEND,
    ST_REFUND
  } state_t;

  // Segment order {g,f,e,d,c,b,a}, active-high
  localparam logic [6:0] SEG_0     = 7'h3F;
  localparam logic [6:0] SEG_1     = 7'h06;
  localparam logic [6:0] SEG_2     = 7'h5B;
  localparam logic [6:0] SEG_3     = 7'h4F;
  localparam logic [6:0] SEG_4     = 7'h66;
  localparam logic [6:0] SEG_5     = 7'h6D;
  localparam logic [6:0] SEG_6     = 7'h7D;
  localparam logic [6:0] SEG_7     = 7'h07;
  localparam logic [6:0] SEG_8     = 7'h7F;
  localparam logic [6:0] SEG_9     = 7'h6F;
  localparam logic [6:0] SEG_BLANK = 7'h00;

  function automatic logic [6:0] seg_code(input logic [3:0] d);
    case (d)
      4'd0:    return SEG_0;
      4'd1:    return SEG_1;
      4'd2:    return SEG_2;
      4'd3:    return SEG_3;
      4'd4:    return SEG_4;
      4'd5:    return SEG_5;
      4'd6:    return SEG_6;
      4'd7:    return SEG_7;
      4'd8:    return SEG_8;
      4'd9:    return SEG_9;
      default: return SEG_BLANK;
    endcase
  endfunction

  function automatic logic [3:0] bcd_digit(input int unsigned value, input int unsigned idx);
    int unsigned v;
    v = value;
    for (int unsigned k = 0; k < idx; k++) v = v / 10;
    return 4'(v % 10);
  endfunction

endpackage

// File: rtl/vending_if.sv
// Button inputs and motor/display outputs of the vending controller.
interface vending_if #(
  parameter int unsigned N_PROD   = 4,
  parameter int unsigned CREDIT_W = 7,
  parameter int unsigned DIGITS   = 2
);
  logic                coin;
  logic [N_PROD-1:0]   sel;
  logic                cancel;
  logic [N_PROD-1:0]   motor;
  logic                refund;
  logic                deny;
  logic                busy;
  logic [CREDIT_W-1:0] credit;
  logic [6:0]          seg;
  logic [DIGITS-1:0]   an;

  modport master (
    output coin, sel, cancel,
    input  motor, refund, deny, busy, credit, seg, an
  );

  modport slave (
    input  coin, sel, cancel,
    output motor, refund, deny, busy, credit, seg, an
  );
endinterface

// File: rtl/vending_display.sv
// Multiplexed 7-segment display of the credit, units digit on an[0].
module vending_display import vending_pkg::*; #(
  parameter int unsigned CREDIT_W   = 7,
  parameter int unsigned DIGITS     = 2,
  parameter int unsigned MUX_CYCLES = 100_000
) (
  input  logic                clk,
  input  logic                reset,
  input  logic [CREDIT_W-1:0] credit,
  output logic [6:0]          seg,
  output logic [DIGITS-1:0]   an
);
  localparam int unsigned MUX_W = $clog2(MUX_CYCLES + 1);
  localparam int unsigned DIG_W = (DIGITS > 1) ? $clog2(DIGITS) : 1;

  logic [MUX_W-1:0]  r_mux_cnt;
  logic [DIG_W-1:0]  r_digit;
  logic [DIG_W-1:0]  w_digit_nxt;
  logic              w_wrap;
  logic [3:0]        w_bcd;
  logic [DIGITS-1:0] w_an_nxt;
  logic [DIGITS-1:0] r_an;
  logic [6:0]        r_seg;

  // seg and an are both registered from the next digit index, so they switch together
  always_comb begin
    w_wrap      = (r_mux_cnt == MUX_W'(MUX_CYCLES - 1));
    w_digit_nxt = r_digit;
    if (w_wrap) w_digit_nxt = (r_digit == DIG_W'(DIGITS - 1)) ? '0 : r_digit + 1'b1;
    w_bcd    = '0;
    w_an_nxt = '0;
    for (int unsigned d = 0; d < DIGITS; d++) begin
      if (w_digit_nxt == DIG_W'(d)) begin
        w_bcd       = bcd_digit(32'(credit), d);
        w_an_nxt[d] = 1'b1;
      end
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_mux_cnt <= '0;
      r_digit   <= '0;
      r_an      <= DIGITS'(1);
      r_seg     <= SEG_0;
    end else begin
      r_mux_cnt <= w_wrap ? '0 : r_mux_cnt + 1'b1;
      r_digit   <= w_digit_nxt;
      r_an      <= w_an_nxt;
      r_seg     <= seg_code(w_bcd);
    end
  end

  assign seg = r_seg;
  assign an  = r_an;

endmodule

// File: rtl/vending_core.sv
// Vending controller: synchronised button edges drive a credit register and
// an IDLE/VEND/REFUND FSM; credit is shown on the multiplexed display.
module vending_core import vending_pkg::*; #(
  parameter int unsigned                  N_PROD        = 4,
  parameter int unsigned                  CREDIT_W      = 7,
  parameter int unsigned                  COIN_VALUE    = 5,
  parameter int unsigned                  CREDIT_MAX    = 95,
  parameter logic [N_PROD*CREDIT_W-1:0]   PRICES        = {7'd20, 7'd15, 7'd5, 7'd5},
  parameter int unsigned                  MOTOR_CYCLES  = 50_000_000,
  parameter int unsigned                  REFUND_CYCLES = 25_000_000,
  parameter int unsigned                  MUX_CYCLES    = 100_000,
  parameter int unsigned                  DIGITS        = 2
) (
  input logic      clk,
  input logic      reset,
  vending_if.slave bus
);
  localparam int unsigned IN_W    = N_PROD + 2;
  localparam int unsigned T_MAX   = (MOTOR_CYCLES > REFUND_CYCLES) ? MOTOR_CYCLES : REFUND_CYCLES;
  localparam int unsigned TIMER_W = $clog2(T_MAX + 1);
  localparam logic [CREDIT_W:0]   COIN_EXT    = (CREDIT_W+1)'(COIN_VALUE);
  localparam logic [CREDIT_W:0]   MAX_EXT     = (CREDIT_W+1)'(CREDIT_MAX);
  localparam logic [TIMER_W-1:0]  MOTOR_LOAD  = TIMER_W'(MOTOR_CYCLES - 1);
  localparam logic [TIMER_W-1:0]  REFUND_LOAD = TIMER_W'(REFUND_CYCLES - 1);

  logic [IN_W-1:0]     w_in, r_sync1, r_sync2, r_prev, w_edge;
  logic                w_coin_e, w_cancel_e;
  logic [N_PROD-1:0]   w_sel_e;
  logic                w_sel_hit;
  logic [N_PROD-1:0]   w_sel_oh;
  logic [CREDIT_W-1:0] w_price;
  logic [CREDIT_W:0]   w_coin_sum;

  state_t              r_state, w_state_nxt;
  logic [CREDIT_W-1:0] r_credit, w_credit_nxt;
  logic [TIMER_W-1:0]  r_timer, w_timer_nxt;
  logic [N_PROD-1:0]   r_motor, w_motor_nxt;
  logic                r_refund, w_refund_nxt;
  logic                r_deny, w_deny_nxt;
  logic                r_busy;
  logic [6:0]          w_seg;
  logic [DIGITS-1:0]   w_an;

  assign w_in = {bus.coin, bus.cancel, bus.sel};

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_sync1 <= '0;
      r_sync2 <= '0;
      r_prev  <= '0;
    end else begin
      r_sync1 <= w_in;
      r_sync2 <= r_sync1;
      r_prev  <= r_sync2;
    end
  end

  assign w_edge     = r_sync2 & ~r_prev;
  assign w_coin_e   = w_edge[N_PROD+1];
  assign w_cancel_e = w_edge[N_PROD];
  assign w_sel_e    = w_edge[N_PROD-1:0];

  // Scan from the top so the lowest asserted index is the last to win
  always_comb begin
    w_sel_hit = 1'b0;
    w_sel_oh  = '0;
    w_price   = '0;
    for (int unsigned i = N_PROD; i > 0; i--) begin
      if (w_sel_e[i-1]) begin
        w_sel_hit     = 1'b1;
        w_sel_oh      = '0;
        w_sel_oh[i-1] = 1'b1;
        w_price       = PRICES[(i-1)*CREDIT_W +: CREDIT_W];
      end
    end
  end

  always_comb begin
    w_state_nxt  = r_state;
    w_credit_nxt = r_credit;
    w_timer_nxt  = r_timer;
    w_motor_nxt  = r_motor;
    w_refund_nxt = 1'b0;
    w_deny_nxt   = 1'b0;
    w_coin_sum   = {1'b0, r_credit} + COIN_EXT;

    if (w_coin_e) begin
      if (w_coin_sum <= MAX_EXT) w_credit_nxt = CREDIT_W'(w_coin_sum);
      else                       w_deny_nxt   = 1'b1;
    end

    case (r_state)
      ST_IDLE: begin
        if (w_sel_hit) begin
          if ({1'b0, r_credit} >= {1'b0, w_price}) begin
            w_credit_nxt = w_credit_nxt - w_price;
            w_motor_nxt  = w_sel_oh;
            w_timer_nxt  = MOTOR_LOAD;
            w_state_nxt  = ST_VEND;
          end else begin
            w_deny_nxt = 1'b1;
          end
        end else if (w_cancel_e) begin
          if (r_credit != '0) begin
            w_state_nxt = ST_REFUND;
            w_timer_nxt = '0;
          end else begin
            w_deny_nxt = 1'b1;
          end
        end
      end
      ST_VEND: begin
        if (r_timer == '0) begin
          w_motor_nxt = '0;
          w_state_nxt = ST_IDLE;
        end else begin
          w_timer_nxt = r_timer - 1'b1;
        end
      end
      ST_REFUND: begin
        if (r_timer == '0) begin
          if ({1'b0, r_credit} >= COIN_EXT) begin
            w_refund_nxt = 1'b1;
            w_credit_nxt = w_credit_nxt - CREDIT_W'(COIN_VALUE);
            w_timer_nxt  = REFUND_LOAD;
          end else if (r_credit == '0) begin
            w_state_nxt = ST_IDLE;
          end
        end else begin
          w_timer_nxt = r_timer - 1'b1;
        end
      end
      default: w_state_nxt = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state  <= ST_IDLE;
      r_credit <= '0;
      r_timer  <= '0;
      r_motor  <= '0;
      r_refund <= 1'b0;
      r_deny   <= 1'b0;
      r_busy   <= 1'b0;
    end else begin
      r_state  <= w_state_nxt;
      r_credit <= w_credit_nxt;
      r_timer  <= w_timer_nxt;
      r_motor  <= w_motor_nxt;
      r_refund <= w_refund_nxt;
      r_deny   <= w_deny_nxt;
      r_busy   <= (w_state_nxt != ST_IDLE);
    end
  end

  vending_display #(
    .CREDIT_W   (CREDIT_W),
    .DIGITS     (DIGITS),
    .MUX_CYCLES (MUX_CYCLES)
  ) u_display (
    .clk    (clk),
    .reset  (reset),
    .credit (r_credit),
    .seg    (w_seg),
    .an     (w_an)
  );

  assign bus.motor  = r_motor;
  assign bus.refund = r_refund;
  assign bus.deny   = r_deny;
  assign bus.busy   = r_busy;
  assign bus.credit = r_credit;
  assign bus.seg    = w_seg;
  assign bus.an     = w_an;

endmodule

// File: tb/tb_vending_core.sv
// Directed scenarios plus random button traffic, checked every cycle
// against a behavioural model of the vending rules.
module tb_vending_core;
  localparam int COIN   = 5;
  localparam int CMAX   = 95;
  localparam int MOTOR  = 20;
  localparam int REFUND = 4;
  localparam int MUX    = 3;
  localparam int DIGITS = 2;
  localparam int PRICE [4] = '{5, 5, 15, 20};
  localparam logic [6:0] SEGTAB [10] =
    '{7'h3F, 7'h06, 7'h5B, 7'h4F, 7'h66, 7'h6D, 7'h7D, 7'h07, 7'h7F, 7'h6F};

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  vending_if #(.N_PROD(4), .CREDIT_W(7), .DIGITS(DIGITS)) bus ();

  vending_core #(
    .N_PROD        (4),
    .CREDIT_W      (7),
    .COIN_VALUE    (COIN),
    .CREDIT_MAX    (CMAX),
    .PRICES        ({7'd20, 7'd15, 7'd5, 7'd5}),
    .MOTOR_CYCLES  (MOTOR),
    .REFUND_CYCLES (REFUND),
    .MUX_CYCLES    (MUX),
    .DIGITS        (DIGITS)
  ) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  int errors = 0;
  int checks = 0;
  logic chk_on = 1'b0;

  task automatic chk(input string nm, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d at %0t", nm, act, exp, $time);
    end
  endtask

  // ---------------- behavioural model ----------------
  int m_credit = 0, m_mode = 0, m_left = 0, m_prod = 0, m_wait = 0;
  int m_ref = 0, m_deny = 0, m_n = 0, m_segc = 0;
  logic [5:0] h0 = '0, h1 = '0, h2 = '0;

  task automatic model_reset();
    m_credit = 0; m_mode = 0; m_left = 0; m_prod = 0; m_wait = 0;
    m_ref = 0; m_deny = 0; m_n = 0; m_segc = 0;
    h0 = '0; h1 = '0; h2 = '0;
  endtask

  task automatic model_step();
    logic [5:0] cur, e;
    int add, sub, lo;
    cur = {bus.coin, bus.cancel, bus.sel};
    e = h1 & ~h2;          // input rose 3 edges ago relative to the one before
    h2 = h1; h1 = h0; h0 = cur;
    m_segc = m_credit;
    m_n++;
    m_ref = 0; m_deny = 0; add = 0; sub = 0;
    if (e[5]) begin
      if (m_credit + COIN <= CMAX) add = COIN;
      else m_deny = 1;
    end
    case (m_mode)
      0: begin
        lo = -1;
        for (int i = 3; i >= 0; i--) if (e[i]) lo = i;
        if (lo >= 0) begin
          if (m_credit >= PRICE[lo]) begin
            sub = PRICE[lo]; m_mode = 1; m_left = MOTOR; m_prod = lo;
          end else m_deny = 1;
        end else if (e[4]) begin
          if (m_credit > 0) begin m_mode = 2; m_wait = 0; end
          else m_deny = 1;
        end
      end
      1: begin
        m_left--;
        if (m_left == 0) m_mode = 0;
      end
      default: begin
        if (m_wait == 0) begin
          if (m_credit >= COIN) begin m_ref = 1; sub = COIN; m_wait = REFUND - 1; end
          else if (m_credit == 0) m_mode = 0;
        end else m_wait--;
      end
    endcase
    m_credit = m_credit + add - sub;
  endtask

  always @(posedge clk or posedge reset) begin
    if (reset) model_reset();
    else model_step();
  end

  function automatic int exp_motor();
    return (m_left > 0) ? (1 << m_prod) : 0;
  endfunction

  function automatic int exp_digit_idx();
    return (m_n / MUX) % DIGITS;
  endfunction

  function automatic int exp_seg();
    int v;
    v = m_segc;
    if (exp_digit_idx() == 1) v = v / 10;
    return int'(SEGTAB[v % 10]);
  endfunction

  // ---------------- compare + monitors ----------------
  int cyc = 0;
  int deny_cnt = 0;
  int motor_hist [16];
  int busy_cnt = 0;
  int rtimes [$];

  always @(negedge clk) begin
    cyc++;
    if (chk_on) begin
      chk("motor",  int'(bus.motor),  exp_motor());
      chk("refund", int'(bus.refund), m_ref);
      chk("deny",   int'(bus.deny),   m_deny);
      chk("busy",   int'(bus.busy),   (m_mode != 0) ? 1 : 0);
      chk("credit", int'(bus.credit), m_credit);
      chk("an",     int'(bus.an),     1 << exp_digit_idx());
      chk("seg",    int'(bus.seg),    exp_seg());
    end
    if (bus.deny) deny_cnt++;
    if (bus.busy) busy_cnt++;
    motor_hist[bus.motor]++;
    if (bus.refund) rtimes.push_back(cyc);
  end

  task automatic clear_mon();
    deny_cnt = 0;
    busy_cnt = 0;
    for (int i = 0; i < 16; i++) motor_hist[i] = 0;
    rtimes.delete();
  endtask

  // which: 0 coin, 1 sel, 2 cancel
  task automatic press(input int which, input logic [3:0] selv);
    @(negedge clk);
    case (which)
      0: bus.coin = 1'b1;
      1: bus.sel = selv;
      default: bus.cancel = 1'b1;
    endcase
    repeat (2) @(negedge clk);
    bus.coin = 1'b0; bus.sel = '0; bus.cancel = 1'b0;
    repeat (4) @(negedge clk);
  endtask

  task automatic do_reset();
    @(negedge clk);
    #2 reset = 1'b1;
    @(negedge clk);
    #2 reset = 1'b0;
  endtask

  task automatic wait_idle(input int bound);
    for (int k = 0; k < bound && bus.busy; k++) @(negedge clk);
    chk("idle_timeout", int'(bus.busy), 0);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish, errors=%0d", errors);
    $fatal(1, "watchdog");
  end

  initial begin
    bus.coin = 1'b0; bus.sel = '0; bus.cancel = 1'b0;
    reset = 1'b1;
    repeat (2) @(negedge clk);
    chk_on = 1'b1;
    chk("rst_credit", int'(bus.credit), 0);
    chk("rst_an",     int'(bus.an),     1);
    chk("rst_seg",    int'(bus.seg),    'h3F);
    chk("rst_motor",  int'(bus.motor),  0);
    #2 reset = 1'b0;

    // coin accumulation and display
    repeat (4) press(0, '0);
    chk("s1_credit", int'(bus.credit), 20);
    for (int k = 0; k < 8 && bus.an != 2'b01; k++) @(negedge clk);
    chk("s1_an_units", int'(bus.an), 1);
    chk("s1_seg_units", int'(bus.seg), 'h3F);
    for (int k = 0; k < 8 && bus.an != 2'b10; k++) @(negedge clk);
    chk("s1_an_tens", int'(bus.an), 2);
    chk("s1_seg_tens", int'(bus.seg), 'h5B);

    // saturation
    clear_mon();
    repeat (16) press(0, '0);
    chk("s2_credit", int'(bus.credit), 95);
    chk("s2_deny", deny_cnt, 1);

    // affordable vend, selection during VEND ignored
    do_reset();
    repeat (4) press(0, '0);
    clear_mon();
    press(1, 4'b0100);
    press(1, 4'b0001);
    wait_idle(60);
    chk("s3_motor2_cycles", motor_hist[4], MOTOR);
    chk("s3_busy_cycles", busy_cnt, MOTOR);
    chk("s3_motor0_cycles", motor_hist[1], 0);
    chk("s3_credit", int'(bus.credit), 5);

    // unaffordable, then simultaneous selections
    do_reset();
    repeat (2) press(0, '0);
    clear_mon();
    press(1, 4'b1000);
    chk("s4_deny", deny_cnt, 1);
    chk("s4_credit", int'(bus.credit), 10);
    chk("s4_no_motor", motor_hist[8], 0);
    clear_mon();
    press(1, 4'b0011);
    wait_idle(60);
    chk("s4_motor0_cycles", motor_hist[1], MOTOR);
    chk("s4_motor1_cycles", motor_hist[2], 0);
    chk("s4_credit2", int'(bus.credit), 5);

    // refund
    do_reset();
    repeat (3) press(0, '0);
    clear_mon();
    press(2, '0);
    wait_idle(60);
    chk("s5_pulses", rtimes.size(), 3);
    if (rtimes.size() >= 3) begin
      chk("s5_gap1", rtimes[1] - rtimes[0], REFUND);
      chk("s5_gap2", rtimes[2] - rtimes[1], REFUND);
    end
    chk("s5_credit", int'(bus.credit), 0);
    repeat (3) press(0, '0);
    clear_mon();
    press(2, '0);
    press(0, '0);
    wait_idle(80);
    chk("s5_pulses_extended", rtimes.size(), 4);
    chk("s5_credit2", int'(bus.credit), 0);

    // reset during vend
    do_reset();
    repeat (4) press(0, '0);
    press(1, 4'b0001);
    chk("s6_in_vend", int'(bus.motor), 1);
    @(negedge clk);
    #2 reset = 1'b1;
    #1;
    chk("s6_motor_rst", int'(bus.motor), 0);
    chk("s6_credit_rst", int'(bus.credit), 0);
    @(negedge clk);
    #2 reset = 1'b0;
    press(0, '0);
    chk("s6_credit_after", int'(bus.credit), 5);

    // random traffic
    repeat (3000) begin
      @(negedge clk);
      if ($urandom_range(0, 999) == 0) begin
        #2 reset = 1'b1;
        @(negedge clk);
        #2 reset = 1'b0;
      end else begin
        bus.coin   = ($urandom_range(0, 2) == 0);
        bus.sel    = ($urandom_range(0, 9) == 0) ? 4'($urandom) : 4'b0000;
        bus.cancel = ($urandom_range(0, 19) == 0);
      end
    end
    bus.coin = 1'b0; bus.sel = '0; bus.cancel = 1'b0;
    repeat (10) @(negedge clk);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
